note_player: RTL and testbench
==============================

Name: note_player

Overview:
- Downstream consumer of the song reader's {note, duration, new_note} stream.
- Latches each note and looks up its phase increment in a registered frequency ROM.
- Holds that increment on step_size for `duration` beats, then pulses note_done so the reader advances.
- step_size feeds the sine/sample generator; 0 means silence.

Parameters:
- NOTE_WIDTH, 6, width of note code; code 0 = rest.
- DUR_WIDTH, 6, width of duration, counted in beats.
- STEP_WIDTH, 20, width of phase-increment output and of frequency ROM entries.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset: 0 resets, no clock needed.
- play  input  1  1 = playing; 0 = paused (counters frozen, output silent).
- new_note  input  1  one-cycle pulse: note/duration valid, load them.
- note  input  NOTE_WIDTH  note code to play.
- duration  input  DUR_WIDTH  length in beats.
- beat  input  1  one-cycle tempo tick from the beat generator.
- step_size  output  STEP_WIDTH  phase increment to the sample generator.
- note_active  output  1  1 while a non-rest note is sounding.
- note_done  output  1  registered one-cycle pulse at end of note.

Behaviour:
- Reset (reset==0, asynchronous):
  - State goes to IDLE.
  - step_size=0, note_active=0, note_done=0.
  - Captured note, duration and beat counter all go to 0.
  - Mid-note reset aborts the note; no note_done is emitted.
- States: IDLE, LOOKUP, PLAYING, DONE. All registered outputs are driven from state and registers only.
- IDLE: step_size=0. new_note captures note and duration, then goes to LOOKUP.
- LOOKUP:
  - Exactly one cycle, covering the frequency ROM read latency (address = captured note).
  - Next cycle loads step_reg = (note==0) ? 0 : rom_out, and beat_cnt = duration.
  - duration==0 goes directly to DONE; otherwise to PLAYING.
- PLAYING:
  - play=1 and beat=1: if beat_cnt==1 go to DONE, else decrement beat_cnt.
  - play=0: beat ignored, beat_cnt held, step_size forced to 0.
  - step_reg is retained, so resuming play restores the output with no re-lookup.
- DONE: note_done=1 for exactly one cycle, step_size=0, then IDLE.
- Output mapping:
  - step_size = step_reg only in PLAYING with play=1; otherwise 0.
  - note_active = PLAYING & play & (captured note != 0).
- Latency:
  - new_note to first non-zero step_size is 2 cycles.
  - The last counted beat to the note_done pulse is 1 cycle.
- Priority and simultaneous events:
  - new_note beats beat in the same cycle. new_note in LOOKUP or PLAYING recaptures and restarts at LOOKUP, with no note_done for the aborted note.
  - new_note in DONE: note_done still pulses, the new note is captured, and the next state is LOOKUP instead of IDLE.
- new_note is accepted regardless of play. The count only advances while play=1.
- Widths: beat_cnt is DUR_WIDTH bits, unsigned. It is never decremented below 1, so there is no wrap.

Optional Feature:
- Macro: NOTE_PLAYER_ARTICULATION_EN.
- Defined: when duration >= 2, step_size is forced to 0 (note_active=0) during the final beat (beat_cnt==1), giving an audible gap between repeated notes. The note_done timing is unchanged.
- Undefined: step_size is held for the full duration.

Decomposition:
- Shared package `music_pkg` holds:
  - NOTE_WIDTH, DUR_WIDTH, STEP_WIDTH.
  - NOTE_REST = 0.
  - State encoding: IDLE=2'b00, LOOKUP=2'b01, PLAYING=2'b10, DONE=2'b11.
- Sub-module `frequency_rom`:
  - 2^NOTE_WIDTH x STEP_WIDTH, registered output (1-cycle latency), inputs clk and addr.
  - Shared with the testbench reference model.
- All flops are async active-low reset registers.

Test Plan:
- Basic note: note=49, duration=3, play=1, beat every 8 cycles.
  - step_size equals frequency_rom[49] from cycle 2 after new_note.
  - note_done pulses once, 1 cycle after the 3rd beat; step_size=0 afterwards.
- Rest and zero duration:
  - note=0, duration=2: step_size stays 0, note_active=0, note_done after 2 beats.
  - note=10, duration=0: note_done 2 cycles after new_note, step_size never non-zero.
- Pause: note=20, duration=4, with play=0 after the 1st beat for 5 beats.
  - step_size=0 and note_active=0 while paused; no note_done.
  - After resume, note_done follows the 3 remaining beats.
- Collision: new_note(note=30, duration=5) in the same cycle as a beat during PLAYING.
  - Old note aborted, no note_done for it.
  - Output becomes frequency_rom[30] 2 cycles later; 5 full beats are counted.
- Async reset: reset=0 mid-PLAYING, between clock edges.
  - step_size, note_active and note_done are 0 immediately.
  - After release, no note_done is emitted until a new_note arrives.
- Articulation (macro defined): note=49, duration=3.
  - step_size = rom value for beats 1-2 and 0 during beat 3; note_done timing identical to the undefined build.

Source files
------------

// File: rtl/music_pkg.sv
// Shared note-player definitions: widths, rest code, FSM encoding and the
// phase-increment table used by the frequency ROM.
package music_pkg;

    localparam int unsigned NOTE_WIDTH = 6;
    localparam int unsigned DUR_WIDTH  = 6;
    localparam int unsigned STEP_WIDTH = 20;

    localparam logic [NOTE_WIDTH-1:0] NOTE_REST = NOTE_WIDTH'(0);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOOKUP  = 2'b01,
        PLAYING = 2'b10,
        DONE    = 2'b11
    } state_e;

    // Equal-tempered phase increment: one base octave of 12 semitones,
    // doubled per octave above it. Note 1 is the lowest pitch; 0 is the rest.
    function automatic logic [STEP_WIDTH-1:0] note_step(input logic [NOTE_WIDTH-1:0] n);
        logic [STEP_WIDTH-1:0] base;
        int unsigned           idx;
        int unsigned           oct;
        if (n == NOTE_REST) begin
            return '0;
        end
        idx = (32'(n) - 32'd1) % 32'd12;
        oct = (32'(n) - 32'd1) / 32'd12;
        case (idx)
            32'd0:   base = STEP_WIDTH'(1770);
            32'd1:   base = STEP_WIDTH'(1875);
            32'd2:   base = STEP_WIDTH'(1986);
            32'd3:   base = STEP_WIDTH'(2104);
            32'd4:   base = STEP_WIDTH'(2229);
            32'd5:   base = STEP_WIDTH'(2362);
            32'd6:   base = STEP_WIDTH'(2502);
            32'd7:   base = STEP_WIDTH'(2651);
            32'd8:   base = STEP_WIDTH'(2808);
            32'd9:   base = STEP_WIDTH'(2975);
            32'd10:  base = STEP_WIDTH'(3152);
            default: base = STEP_WIDTH'(3340);
        endcase
        return base << oct;
    endfunction

endpackage

// File: rtl/note_player_if.sv
// Note stream in from the song reader, phase increment out to the sample generator.
interface note_player_if;
    import music_pkg::*;

    logic                  play;
    logic                  new_note;
    logic [NOTE_WIDTH-1:0] note;
    logic [DUR_WIDTH-1:0]  duration;
    logic                  beat;
    logic [STEP_WIDTH-1:0] step_size;
    logic                  note_active;
    logic                  note_done;

    modport master (
        output play, new_note, note, duration, beat,
        input  step_size, note_active, note_done
    );

    modport slave (
        input  play, new_note, note, duration, beat,
        output step_size, note_active, note_done
    );

endinterface

// File: rtl/frequency_rom.sv
// Note code to phase increment lookup with a registered output (1-cycle latency).
module frequency_rom
    import music_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NOTE_WIDTH-1:0] addr,
    output logic [STEP_WIDTH-1:0] data
);

    logic [STEP_WIDTH-1:0] data_q;

    // Registered table read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= note_step(addr);
        end
    end

    assign data = data_q;

endmodule

// File: rtl/note_player.sv
// Note player: latches a note, looks up its phase increment, holds it for
// `duration` beats and pulses note_done at the end.
// Optional: NOTE_PLAYER_ARTICULATION_EN silences the final beat of notes
// lasting two or more beats, leaving a gap between repeated notes.
module note_player
    import music_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    note_player_if.slave  bus
);

    state_e                state_q, state_d;
    logic [NOTE_WIDTH-1:0] note_q, note_d;
    logic [DUR_WIDTH-1:0]  dur_q, dur_d;
    logic [DUR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [STEP_WIDTH-1:0] step_reg_q, step_reg_d;
    logic [STEP_WIDTH-1:0] step_size_q, step_size_d;
    logic                  note_active_q, note_active_d;
    logic                  note_done_q, note_done_d;
    logic [STEP_WIDTH-1:0] rom_data;
    logic                  sound_c;

    // ROM is addressed with the note being captured so its data is ready in LOOKUP.
    frequency_rom u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (note_d),
        .data  (rom_data)
    );

    // Next-state, counter and registered-output logic; new_note outranks beat.
    always_comb begin
        state_d    = state_q;
        note_d     = note_q;
        dur_d      = dur_q;
        cnt_d      = cnt_q;
        step_reg_d = step_reg_q;

        case (state_q)
            IDLE: begin
                if (bus.new_note) begin
                    note_d  = bus.note;
                    dur_d   = bus.duration;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.new_note) begin
                    note_d  = bus.note;
                    dur_d   = bus.duration;
                    state_d = LOOKUP;
                end else begin
                    cnt_d      = dur_q;
                    step_reg_d = (note_q == NOTE_REST) ? '0 : rom_data;
                    state_d    = (dur_q == DUR_WIDTH'(0)) ? DONE : PLAYING;
                end
            end
            PLAYING: begin
                if (bus.new_note) begin
                    note_d  = bus.note;
                    dur_d   = bus.duration;
                    state_d = LOOKUP;
                end else if (bus.play && bus.beat) begin
                    if (cnt_q == DUR_WIDTH'(1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - DUR_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                if (bus.new_note) begin
                    note_d  = bus.note;
                    dur_d   = bus.duration;
                    state_d = LOOKUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        sound_c = (state_d == PLAYING) && bus.play;
`ifdef NOTE_PLAYER_ARTICULATION_EN
        if ((cnt_d == DUR_WIDTH'(1)) && (dur_d >= DUR_WIDTH'(2))) begin
            sound_c = 1'b0;
        end
`endif
        step_size_d   = sound_c ? step_reg_d : '0;
        note_active_d = sound_c && (note_d != NOTE_REST);
        note_done_d   = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            note_q        <= '0;
            dur_q         <= '0;
            cnt_q         <= '0;
            step_reg_q    <= '0;
            step_size_q   <= '0;
            note_active_q <= 1'b0;
            note_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            note_q        <= note_d;
            dur_q         <= dur_d;
            cnt_q         <= cnt_d;
            step_reg_q    <= step_reg_d;
            step_size_q   <= step_size_d;
            note_active_q <= note_active_d;
            note_done_q   <= note_done_d;
        end
    end

    assign bus.step_size   = step_size_q;
    assign bus.note_active = note_active_q;
    assign bus.note_done   = note_done_q;

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: the driver runs a note-level model and
// queues the expected outputs; the monitor pops and compares each cycle.
module tb_note_player;
    import music_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;

    note_player_if bus ();

    note_player dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [STEP_WIDTH-1:0] step;
        logic                  active;
        logic                  done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: the note being played, its length, and how many beats are left.
    int m_note   = 0;
    int m_dur    = 0;
    int m_left   = 0;
    bit m_lookup = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_note   = 0;
        m_dur    = 0;
        m_left   = 0;
        m_lookup = 1'b0;
    endtask

    // One cycle of stimulus plus the outputs the player should show after the edge.
    task automatic drive(input bit nn, input int n, input int d, input bit bt, input bit pl);
        exp_t e;
        bit   done_now;
        bit   snd;
        @(negedge clk);
        bus.new_note = nn;
        bus.note     = NOTE_WIDTH'(n);
        bus.duration = DUR_WIDTH'(d);
        bus.beat     = bt;
        bus.play     = pl;
        done_now = 1'b0;
        if (nn) begin
            m_note   = n;
            m_dur    = d;
            m_lookup = 1'b1;
            m_left   = 0;
        end else if (m_lookup) begin
            m_lookup = 1'b0;
            if (m_dur == 0) done_now = 1'b1;
            else            m_left   = m_dur;
        end else if (m_left > 0 && pl && bt) begin
            m_left--;
            if (m_left == 0) done_now = 1'b1;
        end
        snd = (m_left > 0) && pl;
`ifdef NOTE_PLAYER_ARTICULATION_EN
        if (m_left == 1 && m_dur >= 2) snd = 1'b0;
`endif
        e.step   = (snd && m_note != 0) ? note_step(NOTE_WIDTH'(m_note)) : '0;
        e.active = snd && (m_note != 0);
        e.done   = done_now;
        exp_q.push_back(e);
    endtask

    // Idle cycles with a beat every 8th cycle.
    task automatic run_beats(input int cycles, input bit pl);
        for (int i = 0; i < cycles; i++) begin
            drive(1'b0, 0, 0, (i % 8) == 7, pl);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_step_size"},   32'(bus.step_size), 32'd0);
        check({tag, "_note_active"}, 32'(bus.note_active), 32'd0);
        check({tag, "_note_done"},   32'(bus.note_done), 32'd0);
    endtask

    // Monitor: compare the DUT against the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("step_size",   32'(bus.step_size),   32'(e.step));
                check("note_active", 32'(bus.note_active), 32'(e.active));
                check("note_done",   32'(bus.note_done),   32'(e.done));
            end
        end
    end

    initial begin
        bus.new_note = 1'b0;
        bus.note     = '0;
        bus.duration = '0;
        bus.beat     = 1'b0;
        bus.play     = 1'b0;
        #3;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Basic note
        drive(1'b1, 49, 3, 1'b0, 1'b1);
        run_beats(40, 1'b1);

        // Rest with duration 2, then a zero-length note
        drive(1'b1, 0, 2, 1'b0, 1'b1);
        run_beats(24, 1'b1);
        drive(1'b1, 10, 0, 1'b0, 1'b1);
        run_beats(6, 1'b1);

        // Pause after the first beat for five beats, then resume
        drive(1'b1, 20, 4, 1'b0, 1'b1);
        run_beats(8, 1'b1);
        run_beats(40, 1'b0);
        run_beats(32, 1'b1);

        // new_note colliding with a beat mid-note
        drive(1'b1, 49, 6, 1'b0, 1'b1);
        run_beats(16, 1'b1);
        drive(1'b1, 30, 5, 1'b1, 1'b1);
        run_beats(48, 1'b1);

        // new_note arriving in the cycle note_done pulses
        drive(1'b1, 5, 1, 1'b0, 1'b1);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        drive(1'b0, 0, 0, 1'b1, 1'b1);
        drive(1'b1, 7, 1, 1'b0, 1'b1);
        run_beats(10, 1'b1);

        // Asynchronous reset mid-note
        drive(1'b1, 49, 5, 1'b0, 1'b1);
        run_beats(12, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        bus.new_note = 1'b0;
        bus.beat     = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        run_beats(40, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(19) == 0), int'($urandom_range(63)),
                  int'($urandom_range(5)), ($urandom_range(3) == 0),
                  ($urandom_range(7) != 0));
        end
        run_beats(4, 1'b1);

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
